// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: tracks in-flight destination registers across DEPTH slots and
// derives stall, per-source forwarding selects, the retire stream and a stall counter.
module pipeline_scoreboard #(
   parameter int DEPTH      = 3,
   parameter int REG_ADDR_W = 5,
   parameter int FORWARD    = 0,
   parameter int ALU_READY  = 1,
   parameter int LOAD_READY = 2,
   parameter int ZERO_REG   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          issue_valid,
   input  logic                          issue_dst_valid,
   input  logic                          issue_dst_late,
   input  logic [REG_ADDR_W-1:0]         issue_dst,
   input  logic                          issue_src0_valid,
   input  logic [REG_ADDR_W-1:0]         issue_src0,
   input  logic                          issue_src1_valid,
   input  logic [REG_ADDR_W-1:0]         issue_src1,
   input  logic                          flush,
   output logic                          stall,
   output logic [$clog2(DEPTH+1)-1:0]    fwd_sel0,
   output logic [$clog2(DEPTH+1)-1:0]    fwd_sel1,
   output logic [DEPTH-1:0]              stage_valid,
   output logic [DEPTH*REG_ADDR_W-1:0]   stage_dst,
   output logic                          retire_valid,
   output logic [REG_ADDR_W-1:0]         retire_dst,
   output logic [31:0]                   stall_count
);
   localparam int SW = $clog2(DEPTH+1);

   logic [DEPTH-1:0]                  vld_q, vld_d, late_q, late_d;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]  dst_q, dst_d;
   logic [31:0]                       cnt_q, cnt_d;
   logic                              hz0, hz1;

   // Scans oldest to youngest so the youngest matching slot has the final say.
   function automatic logic [SW:0] resolve(input logic v, input logic [REG_ADDR_W-1:0] src,
                                           input logic [DEPTH-1:0] vl, input logic [DEPTH-1:0] lt,
                                           input logic [DEPTH-1:0][REG_ADDR_W-1:0] d);
      logic [SW:0] r;
      r = '0;
      for (int k = DEPTH-1; k >= 0; k--)
         if (v && vl[k] && d[k] == src && !(ZERO_REG != 0 && src == '0))
            r = (FORWARD != 0 && k >= (lt[k] ? LOAD_READY : ALU_READY)) ? {1'b0, SW'(k+1)} : {1'b1, SW'(0)};
      return r;
   endfunction

   always_comb begin
      {hz0, fwd_sel0} = resolve(issue_src0_valid, issue_src0, vld_q, late_q, dst_q);
      {hz1, fwd_sel1} = resolve(issue_src1_valid, issue_src1, vld_q, late_q, dst_q);
      stall    = issue_valid & ~flush & (hz0 | hz1);
      vld_d    = {vld_q[DEPTH-2:0], issue_valid & issue_dst_valid & ~stall & ~flush};
      vld_d[1] = vld_d[1] & ~flush;
      late_d   = {late_q[DEPTH-2:0], issue_dst_late};
      dst_d    = {dst_q[DEPTH-2:0], issue_dst};
      cnt_d    = (stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q  <= '0;
         late_q <= '0;
         dst_q  <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         late_q <= late_d;
         dst_q  <= dst_d;
         cnt_q  <= cnt_d;
      end
   end

   assign stage_valid  = vld_q;
   assign stage_dst    = dst_q;
   assign retire_valid = vld_q[DEPTH-1];
   assign retire_dst   = dst_q[DEPTH-1];
   assign stall_count  = cnt_q;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb_pipeline_scoreboard: two scoreboards (stall-only, and forwarding with r0 hardwired)
// checked every cycle against a queue-of-instructions reference model.
module tb_pipeline_scoreboard;
   logic clk = 1'b0;
   logic rst;
   logic issue_valid, issue_dst_valid, issue_dst_late, issue_src0_valid, issue_src1_valid, flush;
   logic [4:0] issue_dst, issue_src0, issue_src1;
   logic        st[2];
   logic [1:0]  s0[2], s1[2];
   logic [2:0]  sv[2];
   logic [14:0] sd[2];
   logic        rv[2];
   logic [4:0]  rd[2];
   logic [31:0] sc[2];

   typedef struct {int dut; int age; bit late; bit [4:0] dst;} ent_t;
   ent_t fl[$];
   int cnt[2];
   int total = 0, bad = 0;
   int ret0 = 0;
   logic [4:0] last_rd0 = 0;

   always #5 clk = ~clk;

   pipeline_scoreboard u0 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_dst_valid(issue_dst_valid),
      .issue_dst_late(issue_dst_late), .issue_dst(issue_dst), .issue_src0_valid(issue_src0_valid),
      .issue_src0(issue_src0), .issue_src1_valid(issue_src1_valid), .issue_src1(issue_src1),
      .flush(flush), .stall(st[0]), .fwd_sel0(s0[0]), .fwd_sel1(s1[0]), .stage_valid(sv[0]),
      .stage_dst(sd[0]), .retire_valid(rv[0]), .retire_dst(rd[0]), .stall_count(sc[0]));

   pipeline_scoreboard #(.FORWARD(1), .ZERO_REG(1)) u1 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_dst_valid(issue_dst_valid),
      .issue_dst_late(issue_dst_late), .issue_dst(issue_dst), .issue_src0_valid(issue_src0_valid),
      .issue_src0(issue_src0), .issue_src1_valid(issue_src1_valid), .issue_src1(issue_src1),
      .flush(flush), .stall(st[1]), .fwd_sel0(s0[1]), .fwd_sel1(s1[1]), .stage_valid(sv[1]),
      .stage_dst(sd[1]), .retire_valid(rv[1]), .retire_dst(rd[1]), .stall_count(sc[1]));

   task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, m, obs, exp);
      end
   endtask

   // Youngest in-flight writer of the source decides; readiness depends on its age and kind.
   function automatic void src_res(input int m, input logic v, input logic [4:0] s, output bit hz, output int sel);
      int best = 99;
      bit bl = 0;
      hz = 0;
      sel = 0;
      foreach (fl[i])
         if (v && fl[i].dut == m && fl[i].dst == s && !(m == 1 && s == 0) && fl[i].age < best) begin
            best = fl[i].age;
            bl = fl[i].late;
         end
      if (best < 99) begin
         if (m == 1 && best >= (bl ? 2 : 1)) sel = best + 1;
         else hz = 1;
      end
   endfunction

   function automatic void model_eval(input int m, output bit est, output int e0, output int e1);
      bit h0, h1;
      src_res(m, issue_src0_valid, issue_src0, h0, e0);
      src_res(m, issue_src1_valid, issue_src1, h1, e1);
      est = issue_valid && !flush && (h0 || h1);
   endfunction

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         bit est;
         int e0, e1;
         logic [2:0] ev = 0;
         logic [4:0] ed[3] = '{0, 0, 0};
         model_eval(m, est, e0, e1);
         foreach (fl[i]) if (fl[i].dut == m) begin ev[fl[i].age] = 1; ed[fl[i].age] = fl[i].dst; end
         chk("stall", m, 32'(st[m]), 32'(est));
         chk("fwd_sel0", m, 32'(s0[m]), e0);
         chk("fwd_sel1", m, 32'(s1[m]), e1);
         chk("stage_valid", m, 32'(sv[m]), 32'(ev));
         for (int k = 0; k < 3; k++) if (ev[k]) chk("stage_dst", m, 32'(sd[m][k*5 +: 5]), 32'(ed[k]));
         chk("retire_valid", m, 32'(rv[m]), 32'(ev[2]));
         if (ev[2]) chk("retire_dst", m, 32'(rd[m]), 32'(ed[2]));
         chk("stall_count", m, sc[m], cnt[m]);
      end
   endtask

   task automatic sample();
      #4;
      check_all();
      if (rv[0]) begin ret0++; last_rd0 = rd[0]; end
   endtask

   task automatic edge_step();
      bit est[2];
      int a, b;
      ent_t nq[$];
      for (int m = 0; m < 2; m++) model_eval(m, est[m], a, b);
      @(posedge clk);
      if (!rst) fl.delete();
      else begin
         foreach (fl[i]) begin
            ent_t e = fl[i];
            if (!(flush && e.age == 0)) begin
               e.age++;
               if (e.age < 3) nq.push_back(e);
            end
         end
         for (int m = 0; m < 2; m++) begin
            if (est[m]) cnt[m]++;
            if (issue_valid && issue_dst_valid && !est[m] && !flush)
               nq.push_back('{m, 0, issue_dst_late, issue_dst});
         end
         fl = nq;
      end
      #1;
   endtask

   task automatic set(input logic v, input logic dv, input logic lt, input logic [4:0] d,
                      input logic a, input logic [4:0] sa, input logic b, input logic [4:0] sb);
      issue_valid = v; issue_dst_valid = dv; issue_dst_late = lt; issue_dst = d;
      issue_src0_valid = a; issue_src0 = sa; issue_src1_valid = b; issue_src1 = sb;
      flush = 0;
   endtask

   task automatic nop();
      set(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      nop();
      repeat (4) begin sample(); edge_step(); end
   endtask

   // Holds the issue inputs while the chosen DUT stalls; returns the number of stall cycles.
   task automatic run_dep(input int m, output int n);
      n = 0;
      sample();
      while (st[m] && n < 10) begin n++; edge_step(); sample(); end
   endtask

   task automatic scen1();
      int n;
      ret0 = 0;
      set(1, 1, 0, 3, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 1, 3, 0, 0); run_dep(0, n);
      chk("s1_stalls", 0, n, 3);
      edge_step();
      drain();
      chk("s1_count", 0, sc[0], 3);
      chk("s1_retire_n", 0, ret0, 1);
      chk("s1_retire_dst", 0, 32'(last_rd0), 3);
   endtask

   initial begin
      int n, cb;
      rst = 0; nop(); cnt = '{0, 0};
      #2;
      check_all();
      @(posedge clk); #1;
      rst = 1;
      scen1();
      // forwarding of an ALU result, then of a load
      set(1, 1, 0, 3, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 1, 3, 0, 0); run_dep(1, n);
      chk("s2_alu_stalls", 1, n, 1);
      chk("s2_alu_sel", 1, 32'(s0[1]), 2);
      edge_step(); drain();
      set(1, 1, 1, 3, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 1, 3, 0, 0); run_dep(1, n);
      chk("s2_load_stalls", 1, n, 2);
      chk("s2_load_sel", 1, 32'(s0[1]), 3);
      edge_step(); drain();
      // youngest writer wins
      set(1, 1, 0, 5, 0, 0, 0, 0); sample(); edge_step();
      set(1, 1, 0, 5, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 0, 0, 1, 5); run_dep(1, n);
      chk("s3_stalls", 1, n, 1);
      chk("s3_sel1", 1, 32'(s1[1]), 2);
      edge_step(); drain();
      // r0 hardwired versus ordinary register
      set(1, 1, 0, 0, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 1, 0, 0, 0); run_dep(1, n);
      chk("s4_zr_stalls", 1, n, 0);
      chk("s4_zr_sel", 1, 32'(s0[1]), 0);
      chk("s4_nozr_stall", 0, 32'(st[0]), 1);
      edge_step(); drain();
      set(1, 1, 0, 0, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 1, 0, 0, 0); run_dep(0, n);
      chk("s4_nozr_stalls", 0, n, 3);
      edge_step(); drain();
      // flush on top of a stalled hazard
      set(1, 1, 0, 7, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 1, 7, 0, 0); sample();
      chk("s5_pre_stall", 0, 32'(st[0]), 1);
      cb = sc[0];
      flush = 1; #1;
      chk("s5_stall", 0, 32'(st[0]), 0);
      chk("s5_stall", 1, 32'(st[1]), 0);
      edge_step();
      nop(); sample();
      chk("s5_slots", 0, 32'(sv[0][1:0]), 0);
      chk("s5_count", 0, sc[0], cb);
      edge_step(); drain();
      // asynchronous reset with full slots and a pending hazard
      set(1, 1, 0, 1, 0, 0, 0, 0); sample(); edge_step();
      set(1, 1, 0, 2, 0, 0, 0, 0); sample(); edge_step();
      set(1, 1, 0, 4, 0, 0, 0, 0); sample(); edge_step();
      set(1, 0, 0, 0, 1, 4, 0, 0); sample();
      chk("s6_pre_stall", 0, 32'(st[0]), 1);
      rst = 0; #1;
      for (int m = 0; m < 2; m++) begin
         chk("s6_stall", m, 32'(st[m]), 0);
         chk("s6_sel0", m, 32'(s0[m]), 0);
         chk("s6_valid", m, 32'(sv[m]), 0);
         chk("s6_retire", m, 32'(rv[m]), 0);
         chk("s6_count", m, sc[m], 0);
      end
      fl.delete(); cnt = '{0, 0};
      nop();
      @(posedge clk); #1;
      rst = 1;
      scen1();
      // random traffic over a small register range to provoke frequent hazards
      for (int i = 0; i < 400; i++) begin
         set($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), 5'($urandom_range(3)),
             $urandom_range(1), 5'($urandom_range(3)), $urandom_range(1), 5'($urandom_range(3)));
         flush = ($urandom_range(7) == 0);
         sample();
         edge_step();
      end
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Parametrised hazard tracker for the pipelined CPU. It supersedes the fixed instruction-register compare of the basic stall detector.
- Tracks the destination register of every in-flight instruction in a DEPTH-slot shift register. Slot 0 is end of decode; slot DEPTH-1 is write back.
- Produces a stall, per-source forwarding selects and a retire stream, with optional forwarding mode, flush support and a saturating stall counter.
- Sits between the issue register and the decode/execute pipeline registers.

Parameters:
- DEPTH, 3: number of tracked slots after issue; legal range 2 to 8.
- REG_ADDR_W, 5: register address width.
- FORWARD, 0: 0 means stall on any match; 1 means forward when the result is ready.
- ALU_READY, 1: lowest slot index whose ALU result can be forwarded.
- LOAD_READY, 2: lowest slot index whose load result can be forwarded; must be at least ALU_READY and at most DEPTH-1.
- ZERO_REG, 0: 1 means register 0 is hardwired and never causes a hazard.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue register holds a real instruction.
- issue_dst_valid  in  1  instruction writes a register.
- issue_dst_late  in  1  result is a memory load, ready only at LOAD_READY.
- issue_dst  in  REG_ADDR_W  destination register.
- issue_src0_valid  in  1  source 0 is used.
- issue_src0  in  REG_ADDR_W  source 0 register.
- issue_src1_valid  in  1  source 1 is used.
- issue_src1  in  REG_ADDR_W  source 1 register.
- flush  in  1  squash the issue instruction and the slot-0 instruction.
- stall  out  1  hold PC and issue register; insert a bubble.
- fwd_sel0  out  $clog2(DEPTH+1)  source 0 operand select: 0 = register file, k+1 = slot k.
- fwd_sel1  out  $clog2(DEPTH+1)  same, for source 1.
- stage_valid  out  DEPTH  bit k is set when slot k holds a register-writing instruction.
- stage_dst  out  DEPTH*REG_ADDR_W  destination of slot k at bits [k*REG_ADDR_W +: REG_ADDR_W].
- retire_valid  out  1  slot DEPTH-1 is valid (write-back enable).
- retire_dst  out  REG_ADDR_W  slot DEPTH-1 destination.
- stall_count  out  32  number of stall cycles since reset.

Behaviour:
- Each slot holds {valid, late, dst}. On reset (rst=0, asynchronous) all slots are invalid and stall_count=0. As a consequence stall=0, fwd_sel*=0 and retire_valid=0 while in reset.
- Every rising edge, with no enable:
  - slot k+1 <= slot k;
  - slot 0 <= {issue_valid & issue_dst_valid & ~stall & ~flush, issue_dst_late, issue_dst}.
- When flush=1: slot 1 additionally receives a bubble (valid=0) instead of slot 0. Flush overrides stall.
- The contents of slot DEPTH-1 are discarded each edge.
- Match for source s (s = 0 or 1): src_valid & slot k valid & dst==src & ~(ZERO_REG & src==0).
- Only the youngest match (lowest k) governs. Older matches are stale and ignored.
- Source hazard, FORWARD=0: any match gives hazard=1 and fwd_sel=0. The write-back slot also counts, because the register file writes at the edge.
- Source hazard, FORWARD=1:
  - ready = k >= (late ? LOAD_READY : ALU_READY);
  - ready gives fwd_sel=k+1 and no hazard;
  - not ready gives hazard=1 and fwd_sel=0.
- No match gives fwd_sel=0.
- stall = issue_valid & ~flush & (hazard0 | hazard1). It is purely combinational from inputs and slots, with no added latency.
- During a stall the issue inputs are held by upstream logic; the block re-evaluates them every cycle.
- stall_count increments on every edge where stall=1 and saturates at 32'hFFFFFFFF.
- retire_valid and retire_dst are registered slot outputs: zero combinational path from the inputs.
- An instruction issued at edge N reaches write back (slot DEPTH-1) after edge N+DEPTH-1.
- An asynchronous reset mid-operation clears all slots immediately, including pending hazards.

Test Plan:
1. Defaults (FORWARD=0). Issue A (dst r3), then B (src0 r3) next cycle -> stall=1 for exactly 3 cycles; B enters slot 0 on the 4th edge; stall_count=3; retire_valid pulses once with retire_dst=3.
2. FORWARD=1. A (dst r3, ALU), then B (src0 r3) -> 1 stall cycle, then fwd_sel0=2 with stall=0. A load (late=1) in place of A -> 2 stall cycles, then fwd_sel0=3.
3. FORWARD=1. Issue A (dst r5), then C (dst r5), then D (src1 r5) -> fwd_sel1 selects C's slot, not A's; with A in slot 1 and C in slot 0 (C not ready), stall=1.
4. ZERO_REG=1. A (dst r0), then B (src0 r0) -> stall=0, fwd_sel0=0, no bubble. ZERO_REG=0 -> 3 stalls.
5. Assert flush in the same cycle as a stalled hazard -> stall=0, slots 0 and 1 invalid after the edge, stall_count unchanged.
6. Drive rst low mid-sequence while slots are full -> all outputs 0 immediately, with no clock; after release, a dependent pair behaves exactly as in scenario 1.
